// File: rtl/gigatron_uart_tx_pkg.sv
// Shared types for the Gigatron UART transmitter.
// Holds the transmitter FSM encoding and the baud divider helper.
package gigatron_uart_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    function automatic int baud_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/gigatron_uart_tx_fifo.sv
// Small synchronous byte FIFO between the byte capture and the serialiser.
// Occupancy lives in its own counter; pointers just wrap.
module gigatron_uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          wr_en;
    logic          rd_en;

    // A push into a full FIFO still fits when a pop frees a slot this cycle.
    always_comb begin
        rd_en    = pop & ~empty;
        wr_en    = push & (~full | rd_en);
        wr_ptr_d = wr_ptr_q + AW'(wr_en);
        rd_ptr_d = rd_ptr_q + AW'(rd_en);
        count_d  = count_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array needs no reset; occupancy guards every read.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/gigatron_uart_tx.sv
// Captures bytes from the HSYNC/VSYNC decoder and sends them as 8N1 UART.
// Edge-detects txready, queues bytes, and shifts them out back to back.
module gigatron_uart_tx
    import gigatron_uart_tx_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          CLOCK_50,
    input  logic                          reset_n,
    input  logic [7:0]                    txdata,
    input  logic                          txready,
    output logic                          uart_txd,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int DIV = baud_div(CLK_HZ, BAUD);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);

    tx_state_e   state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        txd_q, txd_d;
    logic        ovf_q, ovf_d;
    logic        txready_q;
    logic        push;
    logic        pop;
    logic        last;
    logic [7:0]  fifo_dout;
    logic        fifo_full;
    logic        fifo_empty;

    assign push = txready & ~txready_q;
    assign last = (baud_q == CW'(DIV - 1));

    gigatron_uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLOCK_50),
        .rst_n (reset_n),
        .push  (push),
        .pop   (pop),
        .din   (txdata),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // State register plus serialiser datapath.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
            ovf_q     <= 1'b0;
            txready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
            ovf_q     <= ovf_d;
            txready_q <= txready;
        end
    end

    // Next state: pop in IDLE, or at the last STOP clock to chain frames.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (last) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = ST_STOP;
                    else bit_d = bit_q + 3'd1;
                end
            end
            ST_STOP: begin
                if (last) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_dout;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: line level is registered so the pin never glitches.
    always_comb begin
        txd_d = 1'b1;
        unique case (state_q)
            ST_START: txd_d = 1'b0;
            ST_DATA:  txd_d = shift_q[0];
            default:  txd_d = 1'b1;
        endcase
        ovf_d = ovf_q | (push & fifo_full & ~pop);
    end

    assign uart_txd = txd_q;
    assign overflow = ovf_q;
    assign busy     = (state_q != ST_IDLE) | (fifo_count != '0);

    logic unused_aw;
    assign unused_aw = ^AW;

endmodule
